// File: rtl/sdft_synth.sv
// sdft_synth: sliding-DFT synthesis, sums the real parts of one framed bin block and scales by 1/N.
// Latency: eob beat in cycle t -> valid_o/data_o in t+2 (t+3 with SDFT_SYNTH_GAIN_EN); frame_err_o in t+1.
// Backpressure: none; every valid beat is consumed, malformed blocks are dropped and flagged.
module sdft_synth #(
   parameter int    N        = 4096,
   parameter int    DW       = 16,
   parameter int    IDW      = 32,
   parameter int    IMAG_EN  = 1,
   parameter int    IW       = IMAG_EN ? IDW*2 : IDW,
   parameter string SPECTRUM = "full",
   parameter int    AW       = (SPECTRUM == "full") ? $clog2(N) : $clog2(N)-1,
   parameter int    GW       = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [IW-1:0]        data_i,
   input  logic                 sob_i,
   input  logic                 eob_i,
   input  logic                 valid_i,
   output logic [AW-1:0]        gain_idx_o,
   input  logic [GW-1:0]        gain_i,
   output logic signed [DW-1:0] data_o,
   output logic                 valid_o,
   output logic                 sat_alarm_o,
   output logic                 frame_err_o
);

   localparam int LOG2N  = $clog2(N);
   localparam bit HALF   = (SPECTRUM == "half");
`ifdef SDFT_SYNTH_GAIN_EN
   localparam int ACCW   = IDW + LOG2N + 1 + GW;
`else
   localparam int ACCW   = IDW + LOG2N + 1;
`endif
   localparam int CW     = (AW > 0) ? AW : 1;
   localparam int LAST_I = HALF ? N/2 - 1 : N - 1;
   localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_ACC  = 1'b1;

   logic                   r_state;
   logic [CW-1:0]          r_cnt;
   logic                   w_nstate;
   logic [CW-1:0]          w_ncnt;
   logic                   w_add, w_clr, w_fin, w_err, w_bin0;
   logic signed [IDW-1:0]  w_re;
   logic signed [ACCW-1:0] w_term;

   // accumulator-stage controls, either straight from the FSM or one cycle later behind the product register
   logic                   w_s_add, w_s_clr, w_s_fin;
   logic signed [ACCW-1:0] w_s_term;

   logic signed [ACCW-1:0] r_acc;
   logic                   r_done;
   logic signed [ACCW-1:0] w_scaled;
   logic                   w_sat;
   logic signed [DW-1:0]   w_sat_val;

   assign w_re = data_i[IDW-1:0];

   // block framing decode: decides per beat whether to start, accumulate, accept or flag the block
   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      w_add    = 1'b0;
      w_clr    = 1'b0;
      w_fin    = 1'b0;
      w_err    = 1'b0;
      w_bin0   = 1'b0;
      if (valid_i) begin
         if (sob_i) begin
            // a start inside a running block kills that block but opens a new one with this beat
            w_err  = (r_state == ST_ACC);
            w_add  = 1'b1;
            w_clr  = 1'b1;
            w_bin0 = 1'b1;
            if (eob_i || LAST_I == 0) begin
               w_nstate = ST_IDLE;
               w_ncnt   = '0;
               if (eob_i && LAST_I == 0) w_fin = 1'b1;
               else                      w_err = 1'b1;
            end else begin
               w_nstate = ST_ACC;
               w_ncnt   = CW'(1);
            end
         end else if (r_state == ST_ACC) begin
            if (eob_i) begin
               w_nstate = ST_IDLE;
               w_ncnt   = '0;
               if (r_cnt == LAST) begin
                  w_add = 1'b1;
                  w_fin = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end else if (r_cnt == LAST) begin
               w_err    = 1'b1;
               w_nstate = ST_IDLE;
               w_ncnt   = '0;
            end else begin
               w_add  = 1'b1;
               w_ncnt = r_cnt + CW'(1);
            end
         end
      end
   end

   // FSM state, bin counter and framing error pulse
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         frame_err_o <= 1'b0;
      end else begin
         r_state     <= w_nstate;
         r_cnt       <= w_ncnt;
         frame_err_o <= w_err;
      end
   end

`ifdef SDFT_SYNTH_GAIN_EN
   localparam int PW = IDW + GW + 1;
   logic signed [PW-1:0]   w_prod;
   logic signed [PW-1:0]   w_gshift;
   logic signed [ACCW-1:0] w_gext;
   logic                   r_add, r_clr, r_fin;
   logic signed [ACCW-1:0] r_term;
   logic                   w_unused;

   assign gain_idx_o = sob_i ? '0 : r_cnt[AW-1:0];
   assign w_prod     = PW'(w_re) * PW'($signed({1'b0, gain_i}));
   assign w_gshift   = w_prod >>> (GW-1);
   assign w_gext     = ACCW'(w_gshift);
   // half spectrum folds the mirrored bins in by doubling every bin except bin 0
   assign w_term     = (HALF && !w_bin0) ? (w_gext <<< 1) : w_gext;
   assign w_unused   = ^data_i;

   // registered product stage so the multiplier does not sit in front of the accumulator adder
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_add  <= 1'b0;
         r_clr  <= 1'b0;
         r_fin  <= 1'b0;
         r_term <= '0;
      end else begin
         r_add  <= w_add;
         r_clr  <= w_clr;
         r_fin  <= w_fin;
         r_term <= w_term;
      end
   end

   assign w_s_add  = r_add;
   assign w_s_clr  = r_clr;
   assign w_s_fin  = r_fin;
   assign w_s_term = r_term;
`else
   logic signed [ACCW-1:0] w_re_ext;
   logic                   w_unused;

   assign gain_idx_o = '0;
   assign w_re_ext   = ACCW'(w_re);
   // half spectrum folds the mirrored bins in by doubling every bin except bin 0
   assign w_term     = (HALF && !w_bin0) ? (w_re_ext <<< 1) : w_re_ext;
   assign w_unused   = ^{data_i, gain_i};

   assign w_s_add  = w_add;
   assign w_s_clr  = w_clr;
   assign w_s_fin  = w_fin;
   assign w_s_term = w_term;
`endif

   // accumulator: wide enough for N full-scale terms, so it never wraps
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_acc  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_s_fin;
         if (w_s_add) r_acc <= (w_s_clr ? '0 : r_acc) + w_s_term;
      end
   end

   assign w_scaled  = r_acc >>> LOG2N;
   // result fits in DW bits only if every bit from DW-1 upward is a copy of the sign
   assign w_sat     = !((&w_scaled[ACCW-1:DW-1]) || !(|w_scaled[ACCW-1:DW-1]));
   assign w_sat_val = w_scaled[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};

   // scale/saturate register; data_o holds between blocks
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         data_o      <= '0;
         valid_o     <= 1'b0;
         sat_alarm_o <= 1'b0;
      end else begin
         valid_o     <= r_done;
         sat_alarm_o <= r_done && w_sat;
         if (r_done) data_o <= w_sat ? w_sat_val : w_scaled[DW-1:0];
      end
   end

endmodule

// File: tb/tb_sdft_synth.sv
// tb_sdft_synth: directed checks of sdft_synth with N=8, full and half spectrum instances.
// Latency: expects outputs 2 cycles after the accepted eob beat (3 with SDFT_SYNTH_GAIN_EN).
// Backpressure: none on the DUT; the bench drives one beat per cycle or with idle gaps.
module tb_sdft_synth;
   localparam int N   = 8;
   localparam int DW  = 16;
   localparam int IDW = 32;
   localparam int IW  = 64;
   localparam int GW  = 16;
`ifdef SDFT_SYNTH_GAIN_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic                 clk = 1'b0;
   logic                 rstn = 1'b0;
   logic [IW-1:0]        data = '0;
   logic                 sob = 1'b0, eob = 1'b0, vf = 1'b0, vh = 1'b0;
   logic                 gain_mode = 1'b0;
   logic [2:0]           gidx_f;
   logic [1:0]           gidx_h;
   logic [GW-1:0]        gain_f;
   logic signed [DW-1:0] dat_f, dat_h;
   logic                 vld_f, vld_h, sat_f, sat_h, err_f, err_h;
   int                   n_checks = 0;
   int                   n_fail = 0;
   int                   n_vld = 0;
   int                   n_err = 0;
   logic signed [DW-1:0] q_dat[$];

   always #5 clk = ~clk;

   // unity gain everywhere, or unity at bin 0 only when gain_mode is set
   assign gain_f = (gain_mode && gidx_f != 3'd0) ? '0 : 16'h8000;

   sdft_synth #(.N(N), .DW(DW), .IDW(IDW), .IMAG_EN(1), .SPECTRUM("full"), .GW(GW)) u_full (
      .clk_i(clk), .rstn_i(rstn), .data_i(data), .sob_i(sob), .eob_i(eob), .valid_i(vf),
      .gain_idx_o(gidx_f), .gain_i(gain_f), .data_o(dat_f), .valid_o(vld_f),
      .sat_alarm_o(sat_f), .frame_err_o(err_f));

   sdft_synth #(.N(N), .DW(DW), .IDW(IDW), .IMAG_EN(1), .SPECTRUM("half"), .GW(GW)) u_half (
      .clk_i(clk), .rstn_i(rstn), .data_i(data), .sob_i(sob), .eob_i(eob), .valid_i(vh),
      .gain_idx_o(gidx_h), .gain_i(16'h8000), .data_o(dat_h), .valid_o(vld_h),
      .sat_alarm_o(sat_h), .frame_err_o(err_h));

   // record every output pulse of the full-spectrum instance
   always @(negedge clk) begin
      if (vld_f) begin
         n_vld++;
         q_dat.push_back(dat_f);
      end
      if (err_f) n_err++;
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat(input logic s, input logic e, input logic signed [31:0] re, input logic half);
      data = {32'd123, re};
      sob  = s;
      eob  = e;
      vf   = !half;
      vh   = half;
      @(posedge clk);
      #1;
      sob = 1'b0;
      eob = 1'b0;
      vf  = 1'b0;
      vh  = 1'b0;
   endtask

   task automatic block_full(input logic signed [31:0] re);
      beat(1'b1, 1'b0, re, 1'b0);
      repeat (6) beat(1'b0, 1'b0, re, 1'b0);
      beat(1'b0, 1'b1, re, 1'b0);
   endtask

   // called in the cycle after the eob beat; checks latency, value, alarm and pulse width
   task automatic expect_out(input string tag, input longint exp_dat, input longint exp_sat);
      check({tag, "_vld_early"}, longint'(vld_f), 0);
      idle(LAT - 1);
      check({tag, "_vld"}, longint'(vld_f), 1);
      check({tag, "_dat"}, longint'(dat_f), exp_dat);
      check({tag, "_sat"}, longint'(sat_f), exp_sat);
      idle(1);
      check({tag, "_vld_pulse"}, longint'(vld_f), 0);
   endtask

   initial begin
      int q0;
      int v0;
      int e0;

      idle(3);
      check("rst_dat", longint'(dat_f), 0);
      check("rst_vld", longint'(vld_f), 0);
      check("rst_sat", longint'(sat_f), 0);
      check("rst_err", longint'(err_f), 0);
      check("rst_gidx", longint'(gidx_f), 0);
      rstn = 1'b1;
      idle(2);

      // full spectrum, constant real part, imaginary part ignored
      block_full(32'sd8);
      expect_out("full8", 8, 0);

      // half spectrum: 8 + 2*(4+4+4) = 32, /8 = 4
      beat(1'b1, 1'b0, 32'sd8, 1'b1);
      beat(1'b0, 1'b0, 32'sd4, 1'b1);
      beat(1'b0, 1'b0, 32'sd4, 1'b1);
      beat(1'b0, 1'b1, 32'sd4, 1'b1);
      idle(LAT - 1);
      check("half_vld", longint'(vld_h), 1);
      check("half_dat", longint'(dat_h), 4);
      check("half_sat", longint'(sat_h), 0);

      // saturation both ways
      block_full(32'sd1048576);
      expect_out("satp", 32767, 1);
      block_full(-32'sd1048576);
      expect_out("satn", -32768, 1);

      // eob on beat 5 is dropped and flagged, data_o holds
      v0 = n_vld;
      beat(1'b1, 1'b0, 32'sd1, 1'b0);
      repeat (3) beat(1'b0, 1'b0, 32'sd1, 1'b0);
      beat(1'b0, 1'b1, 32'sd1, 1'b0);
      check("eob5_err", longint'(err_f), 1);
      check("eob5_vld", longint'(vld_f), 0);
      idle(1);
      check("eob5_err_pulse", longint'(err_f), 0);
      idle(2);
      check("eob5_no_out", longint'(n_vld - v0), 0);
      check("eob5_hold", longint'(dat_f), -32768);
      block_full(-32'sd16);
      expect_out("after_err", -16, 0);

      // sob inside a block restarts with that beat as bin 0
      beat(1'b1, 1'b0, 32'sd5, 1'b0);
      beat(1'b0, 1'b0, 32'sd5, 1'b0);
      beat(1'b1, 1'b0, 32'sd24, 1'b0);
      check("resob_err", longint'(err_f), 1);
      repeat (6) beat(1'b0, 1'b0, 32'sd24, 1'b0);
      beat(1'b0, 1'b1, 32'sd24, 1'b0);
      expect_out("resob", 24, 0);

      // last bin without eob, then a stray eob beat in IDLE is ignored
      v0 = n_vld;
      e0 = n_err;
      beat(1'b1, 1'b0, 32'sd3, 1'b0);
      repeat (7) beat(1'b0, 1'b0, 32'sd3, 1'b0);
      check("noeob_err", longint'(err_f), 1);
      beat(1'b0, 1'b1, 32'sd3, 1'b0);
      idle(3);
      check("noeob_err_cnt", longint'(n_err - e0), 1);
      check("noeob_no_out", longint'(n_vld - v0), 0);

      // gapped block followed by a back-to-back block; -9/8 floors to -2
      q0 = q_dat.size();
      beat(1'b1, 1'b0, 32'sd16, 1'b0);
      repeat (6) begin
         idle(3);
         beat(1'b0, 1'b0, 32'sd16, 1'b0);
      end
      idle(3);
      beat(1'b0, 1'b1, 32'sd16, 1'b0);
      beat(1'b1, 1'b0, -32'sd1, 1'b0);
      repeat (6) beat(1'b0, 1'b0, -32'sd1, 1'b0);
      beat(1'b0, 1'b1, -32'sd2, 1'b0);
      idle(5);
      check("b2b_count", longint'(q_dat.size() - q0), 2);
      if (q_dat.size() >= q0 + 2) begin
         check("b2b_first", longint'(q_dat[q0]), 16);
         check("b2b_second", longint'(q_dat[q0+1]), -2);
      end

      // reset during beat 4 of a block: outputs clear, nothing emitted afterwards
      v0 = n_vld;
      e0 = n_err;
      beat(1'b1, 1'b0, 32'sd7, 1'b0);
      beat(1'b0, 1'b0, 32'sd7, 1'b0);
      beat(1'b0, 1'b0, 32'sd7, 1'b0);
      data = {32'd123, 32'sd7};
      vf   = 1'b1;
      #2;
      rstn = 1'b0;
      #1;
      check("mrst_dat", longint'(dat_f), 0);
      check("mrst_vld", longint'(vld_f), 0);
      check("mrst_sat", longint'(sat_f), 0);
      check("mrst_err", longint'(err_f), 0);
      vf = 1'b0;
      idle(2);
      rstn = 1'b1;
      idle(2);
      repeat (4) beat(1'b0, 1'b0, 32'sd7, 1'b0);
      beat(1'b0, 1'b1, 32'sd7, 1'b0);
      idle(3);
      check("mrst_no_out", longint'(n_vld - v0), 0);
      check("mrst_no_err", longint'(n_err - e0), 0);
      block_full(32'sd40);
      expect_out("post_rst", 40, 0);

`ifdef SDFT_SYNTH_GAIN_EN
      // unity gain at bin 0 only: 8/8 = 1
      gain_mode = 1'b1;
      block_full(32'sd8);
      expect_out("gain", 1, 0);
      gain_mode = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
